// File: rtl/mul_share_arbiter.sv
// mul_share_arbiter
// Round-robin front end that time-shares one fixed-latency pipelined
// multiplier among NUM_REQ clients. One operand pair is issued per cycle.
// A tag pipeline, as deep as the multiplier, follows each issue so that
// every product leaves tagged with the requester that issued it.
//
// Handshake: a transfer on requester i happens on the rising edge where
// req_valid[i] and req_ready[i] are both 1. req_ready is a combinational
// function of req_valid and the round-robin pointer, and it never asserts
// without req_valid. The result side has no backpressure: res_valid is a
// single-cycle pulse, and the client must take res_data/res_id in that cycle.
module mul_share_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int W           = 8,
  parameter int MUL_LATENCY = 3,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*W-1:0] req_a,
  input  logic [NUM_REQ*W-1:0] req_b,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic [2*W-1:0]       mul_p,
  output logic                 res_valid,
  output logic [2*W-1:0]       res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 busy
);

  // Round-robin pointer: the ID of the most recent grant. Its reset value is
  // NUM_REQ-1, so the search starts at requester 0 after reset.
  localparam logic [ID_W-1:0] LAST_RST = ID_W'(NUM_REQ - 1);

  logic [ID_W-1:0] last_q;
  logic [ID_W-1:0] last_d;

  // Tag pipeline: one {v, id} pair per multiplier stage.
  logic [MUL_LATENCY-1:0]           tag_v_q;
  logic [MUL_LATENCY-1:0]           tag_v_d;
  logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_q;
  logic [MUL_LATENCY-1:0][ID_W-1:0] tag_id_d;

  // Arbitration results
  logic            grant_any;
  logic [ID_W-1:0] grant_id;

  // Search for the first valid requester, starting at last+1 and wrapping.
  // The inner loop uses constant indices so that NUM_REQ need not be a
  // power of two.
  always_comb begin
    int cand;
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_q) + off;
      if (cand >= NUM_REQ) begin
        cand = cand - NUM_REQ;
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && (cand == i) && req_valid[i]) begin
          grant_any = 1'b1;
          grant_id  = ID_W'(i);
        end
      end
    end
  end

  // Produce the one-hot ready and mux the granted operands. When nothing is
  // granted, ready is all zeros and both operands are 0.
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_any && (grant_id == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        mul_a        = req_a[i*W +: W];
        mul_b        = req_b[i*W +: W];
      end
    end
  end

  // Advance the pointer only when a grant happens.
  always_comb begin
    last_d = last_q;
    if (grant_any) begin
      last_d = grant_id;
    end
  end

  // Shift the tag pipeline. Stage 0 records this cycle's issue.
  always_comb begin
    tag_v_d     = '0;
    tag_id_d    = '0;
    tag_v_d[0]  = grant_any;
    tag_id_d[0] = grant_id;
    for (int k = 1; k < MUL_LATENCY; k++) begin
      tag_v_d[k]  = tag_v_q[k-1];
      tag_id_d[k] = tag_id_q[k-1];
    end
  end

  // State registers. Reset drops every in-flight tag, so stale multiplier
  // output after reset is never flagged as a result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q   <= LAST_RST;
      tag_v_q  <= '0;
      tag_id_q <= '0;
    end else begin
      last_q   <= last_d;
      tag_v_q  <= tag_v_d;
      tag_id_q <= tag_id_d;
    end
  end

  // Result bus. Data and ID are forced to 0 outside a valid pulse.
  always_comb begin
    res_valid = tag_v_q[MUL_LATENCY-1];
    res_id    = res_valid ? tag_id_q[MUL_LATENCY-1] : '0;
    res_data  = res_valid ? mul_p : '0;
    busy      = |tag_v_q;
  end

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed testbench for mul_share_arbiter with a 3-stage pipelined
// multiplier model attached to mul_a/mul_b/mul_p.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int W       = 8;
  localparam int LAT     = 3;
  localparam int ID_W    = 2;

  logic                 clk;
  logic                 rst_n;
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   req_ready;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic [2*W-1:0]       mul_p;
  logic                 res_valid;
  logic [2*W-1:0]       res_data;
  logic [ID_W-1:0]      res_id;
  logic                 busy;

  int checks;
  int errors;

  mul_share_arbiter #(
    .NUM_REQ(NUM_REQ), .W(W), .MUL_LATENCY(LAT), .ID_W(ID_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
    .req_b(req_b), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_p(mul_p), .res_valid(res_valid), .res_data(res_data),
    .res_id(res_id), .busy(busy)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier black-box model: 3 register stages and no reset, so stale
  // products can remain after a DUT reset.
  logic [2*W-1:0] p1, p2, p3;
  initial begin
    p1 = '0;
    p2 = '0;
    p3 = '0;
  end
  always @(posedge clk) begin
    p1 <= mul_a * mul_b;
    p2 <= p1;
    p3 <= p2;
  end
  assign mul_p = p3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Move to 1 time unit after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ops(input int i, input int a, input int b);
    req_a[i*W +: W] = W'(a);
    req_b[i*W +: W] = W'(b);
  endtask

  // Hold reset over two edges, then release just after an edge. The caller
  // continues in cycle 0, the first cycle after release.
  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;

    // Reset state
    cyc();
    cyc();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_id", res_id, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 0);
    chk("rst_mul_a", mul_a, 0);
    rst_n = 1'b1;

    // Single request: 200*250 = 50000, returned in cycle 3
    set_ops(0, 200, 250);
    req_valid = 4'b0001;
    #1;
    chk("single_ready", req_ready, 4'b0001);
    chk("single_mul_a", mul_a, 200);
    chk("single_mul_b", mul_b, 250);
    chk("single_rv_c0", res_valid, 0);
    cyc();
    req_valid = '0;
    #1;
    chk("single_rv_c1", res_valid, 0);
    chk("single_busy_c1", busy, 1);
    cyc();
    chk("single_rv_c2", res_valid, 0);
    cyc();
    chk("single_rv_c3", res_valid, 1);
    chk("single_id_c3", res_id, 0);
    chk("single_data_c3", res_data, 50000);
    cyc();
    chk("single_rv_c4", res_valid, 0);
    chk("single_busy_c4", busy, 0);

    // All four valid for 8 cycles starting from a fresh pointer:
    // a=i+1, b=10, so results are 10,20,30,40,10,... in cycles 3..10
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, i + 1, 10);
    for (int c = 0; c < 12; c++) begin
      req_valid = (c < 8) ? 4'b1111 : 4'b0000;
      #1;
      if (c < 8) begin
        chk("all_ready", req_ready, 32'(1 << (c % 4)));
        chk("all_mul_a", mul_a, (c % 4) + 1);
      end
      chk("all_busy", busy, (c >= 1 && c <= 10) ? 1 : 0);
      if (c >= 3 && c <= 10) begin
        chk("all_rv", res_valid, 1);
        chk("all_id", res_id, (c - 3) % 4);
        chk("all_data", res_data, ((c - 3) % 4 + 1) * 10);
      end else begin
        chk("all_rv_idle", res_valid, 0);
      end
      cyc();
    end

    // Fairness: requesters 0 and 2 held valid, pointer is at 3.
    // Products are 7*3=21 and 9*11=99.
    set_ops(0, 7, 3);
    set_ops(2, 9, 11);
    for (int c = 0; c < 9; c++) begin
      req_valid = (c < 6) ? 4'b0101 : 4'b0000;
      #1;
      if (c < 6) begin
        chk("fair_ready", req_ready, (c % 2 == 0) ? 4'b0001 : 4'b0100);
      end
      if (c >= 3) begin
        chk("fair_rv", res_valid, 1);
        chk("fair_id", res_id, ((c - 3) % 2 == 0) ? 0 : 2);
        chk("fair_data", res_data, ((c - 3) % 2 == 0) ? 21 : 99);
      end
      cyc();
    end

    // Corner products. The pointer is at 2, so requester 1 wins over the wrap.
    set_ops(1, 255, 255);
    set_ops(3, 0, 255);
    req_valid = 4'b0010;
    #1;
    chk("corner_ready1", req_ready, 4'b0010);
    chk("corner_mul_a1", mul_a, 255);
    cyc();
    req_valid = 4'b1000;
    #1;
    chk("corner_ready3", req_ready, 4'b1000);
    chk("corner_mul_a3", mul_a, 0);
    chk("corner_mul_b3", mul_b, 255);
    cyc();
    req_valid = '0;
    cyc();
    chk("corner_rv_ff", res_valid, 1);
    chk("corner_id_ff", res_id, 1);
    chk("corner_data_ff", res_data, 65025);
    cyc();
    chk("corner_rv_zero", res_valid, 1);
    chk("corner_id_zero", res_id, 3);
    chk("corner_data_zero", res_data, 0);
    cyc();
    chk("corner_rv_after", res_valid, 0);

    // Reset mid-flight. The pointer is at 3: issue from 0, then from 1,
    // then pulse reset during cycle 2.
    set_ops(0, 12, 12);
    set_ops(1, 13, 13);
    req_valid = 4'b0001;
    #1;
    chk("rmf_ready_c0", req_ready, 4'b0001);
    cyc();
    req_valid = 4'b0010;
    #1;
    chk("rmf_ready_c1", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    #1;
    chk("rmf_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("rmf_busy_rst", busy, 0);
    chk("rmf_rv_rst", res_valid, 0);
    chk("rmf_data_rst", res_data, 0);
    #1;
    rst_n = 1'b1;
    cyc();
    // Cycle 3: stale 144 is on mul_p and must not appear as a result.
    // Both 0 and 1 request, and the reset pointer picks 0.
    set_ops(0, 5, 6);
    req_valid = 4'b0011;
    #1;
    chk("rmf_rv_c3", res_valid, 0);
    chk("rmf_data_c3", res_data, 0);
    chk("rmf_ready_after", req_ready, 4'b0001);
    cyc();
    req_valid = '0;
    #1;
    chk("rmf_rv_c4", res_valid, 0);
    cyc();
    chk("rmf_rv_c5", res_valid, 0);
    cyc();
    chk("rmf_rv_c6", res_valid, 1);
    chk("rmf_id_c6", res_id, 0);
    chk("rmf_data_c6", res_data, 30);
    cyc();

    // Idle for 10 cycles. The pointer must stay at 0, so the next
    // all-valid cycle grants requester 1.
    for (int c = 0; c < 10; c++) begin
      chk("idle_mul_a", mul_a, 0);
      chk("idle_mul_b", mul_b, 0);
      chk("idle_rv", res_valid, 0);
      chk("idle_data", res_data, 0);
      chk("idle_busy", busy, 0);
      cyc();
    end
    req_valid = 4'b1111;
    #1;
    chk("idle_ptr_kept", req_ready, 4'b0010);
    cyc();
    req_valid = '0;
    cyc();
    cyc();
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
